// File: rtl/qnr_round_stage.sv
// qnr_round_stage
//   Final stage of the JPEG quantizer: rounds the divider's quotient (round
//   half away from zero), applies the coefficient sign, clamps to the 12-bit
//   signed range, buffers results in a 4-entry first-word-fall-through FIFO,
//   and tracks 8x8 block framing through a 64-coefficient sequence checker.
//
//   Ports
//     clk, rst          clock, asynchronous active-high reset
//     div_valid         divider result valid this cycle
//     div_quot          unsigned quotient magnitude (DATA_W bits)
//     div_rem           remainder (COEF_W bits)
//     div_divisor       quantizer divisor that produced the quotient
//     div_sign          sign of the original coefficient (1 = negative)
//     div_last          marks coefficient 63 of a block
//     in_ready          stage can take a result this cycle
//     out_valid/ready   output handshake
//     out_data          signed quantized coefficient
//     out_last          block-end marker aligned with out_data
//     ovf_err           sticky: input offered while in_ready was low
//     seq_err           sticky: div_last seen at the wrong coefficient index
//     sat_cnt           count of clamped coefficients (16-bit, saturating)
//
//   Build option
//     QNR_ROUND_STAT_EN  when defined, sat_cnt counts clamped results that
//                        enter the FIFO; otherwise sat_cnt is tied to zero.

module qnr_round_stage #(
    parameter int DATA_W = 12,
    parameter int COEF_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     div_valid,
    input  logic [DATA_W-1:0]        div_quot,
    input  logic [COEF_W-1:0]        div_rem,
    input  logic [COEF_W-1:0]        div_divisor,
    input  logic                     div_sign,
    input  logic                     div_last,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last,
    output logic                     ovf_err,
    output logic                     seq_err,
    output logic [15:0]              sat_cnt
);

    localparam logic [DATA_W:0]   POS_MAX = {2'b00, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W:0]   NEG_MAX = {2'b01, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W:0]   ONE_MAG = {{DATA_W{1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] ONE_DAT = {{(DATA_W-1){1'b0}}, 1'b1};

    // Magnitude is one bit wider than the quotient so the round-up of an
    // all-ones quotient is not lost. A zero divisor forces the largest
    // magnitude so the result always clamps.
    function automatic logic [DATA_W:0] round_mag(
        input logic [DATA_W-1:0] quot,
        input logic [COEF_W-1:0] rem,
        input logic [COEF_W-1:0] divisor
    );
        logic [DATA_W:0] mag;
        if (divisor == '0)
            mag = {1'b0, {DATA_W{1'b1}}};
        else if ({rem, 1'b0} >= {1'b0, divisor})
            mag = {1'b0, quot} + ONE_MAG;
        else
            mag = {1'b0, quot};
        return mag;
    endfunction

    // The negative range reaches one step further than the positive range.
    // Negating a zero magnitude naturally yields zero.
    function automatic logic signed [DATA_W-1:0] saturate(
        input logic [DATA_W:0] mag,
        input logic            sign
    );
        logic signed [DATA_W-1:0] res;
        if (!sign)
            res = (mag > POS_MAX) ? POS_MAX[DATA_W-1:0] : mag[DATA_W-1:0];
        else if (mag > NEG_MAX)
            res = {1'b1, {(DATA_W-1){1'b0}}};
        else
            res = (~mag[DATA_W-1:0]) + ONE_DAT;
        return res;
    endfunction

`ifdef QNR_ROUND_STAT_EN
    function automatic logic clamps(
        input logic [DATA_W:0] mag,
        input logic            sign
    );
        return sign ? (mag > NEG_MAX) : (mag > POS_MAX);
    endfunction
`endif

    typedef enum logic {
        EXPECT_BODY,
        EXPECT_LAST
    } seq_state_t;

    logic                     accept_p0;
    logic [DATA_W:0]          mag_p0;
    logic signed [DATA_W-1:0] data_p0;

    logic                     vld_p1;
    logic signed [DATA_W-1:0] data_p1;
    logic                     last_p1;

    logic [DATA_W:0]          fifo_mem [4];
    logic [1:0]               wr_ptr;
    logic [1:0]               rd_ptr;
    logic [2:0]               count;
    logic [2:0]               occ;
    logic                     pop_p2;
    logic [DATA_W:0]          head_p2;

    seq_state_t               state, state_nxt;
    logic [5:0]               idx, idx_nxt;
    logic                     seq_hit;

    // ---- p0: input acceptance, rounding and clamping ----
    assign occ       = count + {2'b00, vld_p1};
    assign in_ready  = (occ < 3'd4);
    assign accept_p0 = div_valid & in_ready;
    assign mag_p0    = round_mag(div_quot, div_rem, div_divisor);
    assign data_p0   = saturate(mag_p0, div_sign);

    // ---- p1: single-entry result register ----
    // S1 always drains into the FIFO the following cycle; the in_ready
    // occupancy test guarantees the FIFO has room for it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            vld_p1 <= accept_p0;
            if (vld_p1)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop_p2)
                rd_ptr <= rd_ptr + 2'd1;
            case ({vld_p1, pop_p2})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept_p0) begin
            data_p1 <= data_p0;
            last_p1 <= div_last;
        end
        if (vld_p1)
            fifo_mem[wr_ptr] <= {last_p1, data_p1};
    end

    // ---- p2: FIFO head presented to the output ----
    assign out_valid = (count != 3'd0);
    assign pop_p2    = out_valid & out_ready;
    assign head_p2   = fifo_mem[rd_ptr];
    assign out_data  = out_valid ? head_p2[DATA_W-1:0] : '0;
    assign out_last  = out_valid ? head_p2[DATA_W] : 1'b0;

    // Block framing: the index only advances on accepted inputs. A marker
    // always restarts the block, whether or not it arrived on time.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        seq_hit   = 1'b0;
        if (accept_p0) begin
            if (div_last) begin
                seq_hit   = (state == EXPECT_BODY);
                idx_nxt   = '0;
                state_nxt = EXPECT_BODY;
            end else begin
                seq_hit   = (state == EXPECT_LAST);
                idx_nxt   = idx + 6'd1;
                state_nxt = (idx_nxt == 6'd63) ? EXPECT_LAST : EXPECT_BODY;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EXPECT_BODY;
            idx     <= '0;
            ovf_err <= 1'b0;
            seq_err <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (div_valid && !in_ready)
                ovf_err <= 1'b1;
            if (seq_hit)
                seq_err <= 1'b1;
        end
    end

`ifdef QNR_ROUND_STAT_EN
    logic sat_p1;

    always_ff @(posedge clk) begin
        if (accept_p0)
            sat_p1 <= clamps(mag_p0, div_sign);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_cnt <= '0;
        else if (vld_p1 && sat_p1 && (sat_cnt != 16'hFFFF))
            sat_cnt <= sat_cnt + 16'd1;
    end
`else
    assign sat_cnt = '0;
`endif

endmodule

// File: tb/tb_qnr_round_stage.sv
// Self-checking bench for qnr_round_stage: a scoreboard queue is filled as
// inputs are accepted and drained by an output monitor; scenario tasks check
// reset, rounding/clamping, backpressure, block framing and reset flushing.

module tb_qnr_round_stage;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               div_valid = 1'b0;
    logic [11:0]        div_quot = '0;
    logic [7:0]         div_rem = '0;
    logic [7:0]         div_divisor = '0;
    logic               div_sign = 1'b0;
    logic               div_last = 1'b0;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [11:0] out_data;
    logic               out_last;
    logic               ovf_err;
    logic               seq_err;
    logic [15:0]        sat_cnt;

    int          checks = 0;
    int          failures = 0;
    logic [12:0] exp_q[$];
    int          exp_sat = 0;
    int          exp_idx = 0;
    logic        exp_seq = 1'b0;
    int          last_seen = 0;
    logic [12:0] mon_e;
    logic [15:0] exp_cnt;

    always #5 clk = ~clk;

    qnr_round_stage dut (
        .clk        (clk),
        .rst        (rst),
        .div_valid  (div_valid),
        .div_quot   (div_quot),
        .div_rem    (div_rem),
        .div_divisor(div_divisor),
        .div_sign   (div_sign),
        .div_last   (div_last),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .ovf_err    (ovf_err),
        .seq_err    (seq_err),
        .sat_cnt    (sat_cnt)
    );

    // Integer reference: returns {sat, last, data[11:0]}.
    function automatic logic [13:0] model(input int q, input int r, input int d,
                                          input logic s, input logic l);
        int m, v, c;
        logic sat;
        m = (d == 0) ? 4095 : q + ((2 * r >= d) ? 1 : 0);
        v = s ? -m : m;
        c = (v > 2047) ? 2047 : ((v < -2048) ? -2048 : v);
        sat = (c != v);
        return {sat, l, c[11:0]};
    endfunction

    task automatic send(input int q, input int r, input int d, input logic s,
                        input logic l, output logic acc);
        logic [13:0] e;
        div_valid   = 1'b1;
        div_quot    = q[11:0];
        div_rem     = r[7:0];
        div_divisor = d[7:0];
        div_sign    = s;
        div_last    = l;
        acc = in_ready;
        if (acc) begin
            e = model(q, r, d, s, l);
            exp_q.push_back(e[12:0]);
            if (e[13]) exp_sat++;
            if (l) begin
                if (exp_idx != 63) exp_seq = 1'b1;
                exp_idx = 0;
            end else begin
                if (exp_idx == 63) exp_seq = 1'b1;
                exp_idx = (exp_idx + 1) % 64;
            end
        end
        @(posedge clk); #1;
        div_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        exp_sat = 0;
        exp_idx = 0;
        exp_seq = 1'b0;
        last_seen = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
        @(posedge clk); #1;
    endtask

    // Output monitor: every transfer is compared against the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output: got last=%0b data=%0d, required no output",
                         out_last, out_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({out_last, out_data} !== mon_e) begin
                    failures++;
                    $display("FAIL scoreboard: got last=%0b data=%0d, required last=%0b data=%0d",
                             out_last, out_data, mon_e[12], $signed(mon_e[11:0]));
                end
                if (out_last) last_seen++;
            end
        end
    end

    task automatic test_reset();
        #12;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        checks++; if (out_data !== 12'sd0) begin failures++; $display("FAIL rst_out_data: got %0d required 0", out_data); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL rst_out_last: got %b required 0", out_last); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
        checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL rst_ovf_err: got %b required 0", ovf_err); end
        checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL rst_seq_err: got %b required 0", seq_err); end
        checks++; if (sat_cnt !== 16'd0) begin failures++; $display("FAIL rst_sat_cnt: got %0d required 0", sat_cnt); end
        do_reset();
    endtask

    task automatic test_round();
        logic acc;
        out_ready = 1'b1;
        send(10, 3, 6, 1'b0, 1'b0, acc);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL latency_early: got out_valid=%b required 0", out_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 12'sd11) begin
            failures++;
            $display("FAIL latency_2: got valid=%b data=%0d required valid=1 data=11", out_valid, out_data);
        end
        @(posedge clk); #1;
        send(10, 2, 6, 1'b1, 1'b0, acc);
        send(2047, 5, 8, 1'b1, 1'b0, acc);
        send(2047, 5, 8, 1'b0, 1'b0, acc);
        send(0, 0, 5, 1'b1, 1'b0, acc);
        send(4095, 200, 255, 1'b0, 1'b0, acc);
        for (int i = 0; i < 8; i++)
            send($urandom_range(0, 4095), $urandom_range(0, 255), $urandom_range(0, 255),
                 1'($urandom_range(0, 1)), 1'b0, acc);
        wait_drain();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL round_drain: got %0d pending required 0", exp_q.size()); end
`ifdef QNR_ROUND_STAT_EN
        exp_cnt = 16'(exp_sat);
`else
        exp_cnt = 16'd0;
`endif
        checks++; if (sat_cnt !== exp_cnt) begin failures++; $display("FAIL round_sat_cnt: got %0d required %0d", sat_cnt, exp_cnt); end
    endtask

    task automatic test_backpressure();
        logic acc;
        int nacc;
        do_reset();
        out_ready = 1'b0;
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            send(100 + i * 7, i, 16, 1'(i % 2), 1'b0, acc);
            if (acc) nacc++;
        end
        checks++; if (nacc != 4) begin failures++; $display("FAIL bp_accepted: got %0d required 4", nacc); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %b required 0", in_ready); end
        checks++; if (ovf_err !== 1'b1) begin failures++; $display("FAIL bp_ovf_err: got %b required 1", ovf_err); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || {out_last, out_data} !== exp_q[0]) begin
            failures++;
            $display("FAIL bp_stall_hold: got valid=%b data=%0d required valid=1 data=%0d",
                     out_valid, out_data, $signed(exp_q[0][11:0]));
        end
        out_ready = 1'b1;
        wait_drain();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_drain: got %0d pending required 0", exp_q.size()); end
        checks++; if (ovf_err !== 1'b1) begin failures++; $display("FAIL bp_ovf_sticky: got %b required 1", ovf_err); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back: got %b required 1", in_ready); end
    endtask

    task automatic test_sequence();
        logic acc;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) send(i, 0, 1, 1'b0, (i == 63), acc);
        wait_drain();
        checks++; if (last_seen != 1) begin failures++; $display("FAIL seq_last_count: got %0d required 1", last_seen); end
        checks++; if (seq_err !== exp_seq) begin failures++; $display("FAIL seq_good_block: got %b required %b", seq_err, exp_seq); end
        for (int i = 0; i < 10; i++) send(300 + i, 1, 2, 1'b1, (i == 9), acc);
        wait_drain();
        checks++; if (seq_err !== exp_seq) begin failures++; $display("FAIL seq_early_last: got %b required %b", seq_err, exp_seq); end
        checks++; if (last_seen != 2) begin failures++; $display("FAIL seq_early_passthru: got %0d required 2", last_seen); end
        do_reset();
        for (int i = 0; i < 63; i++) send(i, 0, 3, 1'b0, 1'b0, acc);
        checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL seq_body_63: got %b required 0", seq_err); end
        send(63, 0, 3, 1'b0, 1'b0, acc);
        checks++; if (seq_err !== exp_seq) begin failures++; $display("FAIL seq_missing_last: got %b required %b", seq_err, exp_seq); end
        wait_drain();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL seq_drain: got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_reset_flush();
        logic acc;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(200 + i, 0, 4, 1'b0, 1'b0, acc);
        #2;
        rst = 1'b1;
        exp_q.delete();
        exp_sat = 0;
        exp_idx = 0;
        exp_seq = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid: got %b required 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready: got %b required 1", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_stale: got out_valid=%b required 0", out_valid); end
        send(5, 0, 0, 1'b1, 1'b0, acc);
        wait_drain();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL flush_div0_drain: got %0d pending required 0", exp_q.size()); end
`ifdef QNR_ROUND_STAT_EN
        exp_cnt = 16'(exp_sat);
`else
        exp_cnt = 16'd0;
`endif
        checks++; if (sat_cnt !== exp_cnt) begin failures++; $display("FAIL flush_sat_cnt: got %0d required %0d", sat_cnt, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_round();
        test_backpressure();
        test_sequence();
        test_reset_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
